shift_seq_32: RTL

- Multi-cycle sequential shift unit. It is the iterative counterpart to the single-cycle combinational 32-bit barrel shifter.
- Shifts one bit position per clock under a START/DONE handshake.
- Supports logical left, logical right and arithmetic right shifts.
- Used by the ALU datapath where area matters more than latency. Its result format matches the combinational shifter bit for bit for logical shifts.

---
 rtl/shift_seq_32_pkg.sv | 33 +++
 rtl/shift_seq_32_cnt.sv | 39 +++
 rtl/shift_seq_32.sv | 119 +++++++++++
 3 files changed

// File: rtl/shift_seq_32_pkg.sv
// Shared constants and encodings for the iterative shift unit.
// Widths, FSM state encoding and the {LnR,ARITH} shift-mode encoding.
package shift_seq_32_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        SHS_IDLE  = 2'b00,
        SHS_SHIFT = 2'b01,
        SHS_FIN   = 2'b10
    } shs_state_e;

    // LnR dominates: any left request is a logical left regardless of ARITH.
    typedef enum logic [1:0] {
        SHM_LSR = 2'b00,
        SHM_ASR = 2'b01,
        SHM_LSL = 2'b10
    } shm_mode_e;

    function automatic shm_mode_e decode_mode(input logic lnr, input logic arith);
        shm_mode_e mode;
        if (lnr) begin
            mode = SHM_LSL;
        end else if (arith) begin
            mode = SHM_ASR;
        end else begin
            mode = SHM_LSR;
        end
        return mode;
    endfunction

endpackage

// File: rtl/shift_seq_32_cnt.sv
// Loadable down-counter that tracks how many single-bit shifts remain.
// ONE flags the last shift so the parent can leave SHIFT on that edge.
module shift_cnt_dn #(
    parameter int CNT_W = shift_seq_32_pkg::CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [CNT_W-1:0] DIN,
    input  logic             EN,
    output logic [CNT_W-1:0] Q,
    output logic             ONE
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over decrement; the count never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (LOAD) begin
            cnt_d = DIN;
        end else if (EN && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q   = cnt_q;
    assign ONE = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_seq_32.sv
// Iterative shifter: one bit position per clock under a START/DONE handshake.
// Results match the combinational barrel shifter bit for bit.
module shift_seq_32 #(
    parameter int DATA_W = shift_seq_32_pkg::DATA_W,
    parameter int CNT_W  = shift_seq_32_pkg::CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] D,
    input  logic [31:0]       S,
    input  logic              LnR,
    input  logic              ARITH,
    output logic [DATA_W-1:0] Y,
    output logic              BUSY,
    output logic              DONE
);

    import shift_seq_32_pkg::shs_state_e;
    import shift_seq_32_pkg::SHS_IDLE;
    import shift_seq_32_pkg::SHS_SHIFT;
    import shift_seq_32_pkg::SHS_FIN;
    import shift_seq_32_pkg::shm_mode_e;
    import shift_seq_32_pkg::SHM_LSR;
    import shift_seq_32_pkg::SHM_ASR;
    import shift_seq_32_pkg::SHM_LSL;
    import shift_seq_32_pkg::decode_mode;

    shs_state_e        state_q, state_d;
    shm_mode_e         mode_q, mode_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  n_eff;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_one;
    logic              cnt_load;
    logic              cnt_en;

    // Any amount of 32 or more saturates to a full-width shift.
    assign n_eff = (|S[31:5]) ? CNT_W'(DATA_W) : CNT_W'(S[4:0]);

    shift_cnt_dn #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .CLK  (CLK),
        .RST  (RST),
        .LOAD (cnt_load),
        .DIN  (n_eff),
        .EN   (cnt_en),
        .Q    (cnt_val),
        .ONE  (cnt_one)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        y_d      = y_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            SHS_IDLE: begin
                if (START) begin
                    y_d      = D;
                    mode_d   = decode_mode(LnR, ARITH);
                    cnt_load = 1'b1;
                    state_d  = (n_eff == '0) ? SHS_FIN : SHS_SHIFT;
                end
            end

            SHS_SHIFT: begin
                cnt_en = 1'b1;
                case (mode_q)
                    SHM_LSL: y_d = {y_q[DATA_W-2:0], 1'b0};
                    SHM_ASR: y_d = {y_q[DATA_W-1], y_q[DATA_W-1:1]};
                    default: y_d = {1'b0, y_q[DATA_W-1:1]};
                endcase
                // A zero count here can only follow a corrupted load; leave rather than spin.
                if (cnt_one || (cnt_val == '0)) begin
                    state_d = SHS_FIN;
                end
            end

            SHS_FIN: begin
                state_d = SHS_IDLE;
            end

            default: begin
                state_d = SHS_IDLE;
            end
        endcase

        busy_d = (state_d != SHS_IDLE);
        done_d = (state_d == SHS_FIN);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= SHS_IDLE;
            mode_q  <= SHM_LSR;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Y    = y_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule
